mvu_job_ctrl: RTL and testbench
===============================

// Module: mvu_job_ctrl
// PURPOSE
//  MVU-side receiver of the pito<->MVU CSR job interface. Latches each hart's CSR job
//  descriptor on mvu_start and queues one job per hart. Round-robin arbitration picks one
//  job at a time. Runs a 2-level address loop producing (weight, input, output) address
//  tuples over a valid/ready stream, then raises mvu_irq for the owning hart.
// PARAMETERS
//  NUM_HARTS  8   number of harts (matches `PITO_NUM_HARTS)
//  LEN_W      16  loop-count bits taken from csr_mvu_*length_* [LEN_W-1:0]
// PORTS
//  clk                 in   1             clock
//  rst                 in   1             synchronous reset, active-high
//  mvu_start           in   NUM_HARTS     per-hart job start pulse
//  csr_mvu_wbaseaddr   in   32*NUM_HARTS  weight base address, hart h at [32h+:32] (all csr_* alike)
//  csr_mvu_ibaseaddr   in   32*NUM_HARTS  input base address
//  csr_mvu_obaseaddr   in   32*NUM_HARTS  output base address
//  csr_mvu_{w,i,o}stride_{0,1} in 32*NUM_HARTS  signed inner(0)/outer(1) strides
//  csr_mvu_wlength_0   in   32*NUM_HARTS  inner loop count L0 (shared by all streams)
//  csr_mvu_wlength_1   in   32*NUM_HARTS  outer loop count L1
//  csr_mvu_precision   in   32*NUM_HARTS  passed through with job
//  csr_mvu_quant       in   32*NUM_HARTS  passed through with job
//  mvu_irq             out  NUM_HARTS     job-done interrupt to pito
//  mvu_start_drop      out  NUM_HARTS     1-cycle pulse: start rejected (slot already pending)
//  agu_valid           out  1             address tuple valid
//  agu_ready           in   1             consumer accepts tuple
//  agu_waddr/iaddr/oaddr out 32           current addresses
//  agu_last            out  1             final tuple of job
//  agu_hart            out  $clog2(NUM_HARTS) owning hart
//  job_precision/job_quant out 32         latched descriptor fields of active job
//  busy                out  1             state!=IDLE or any slot pending
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, all pending clear, rr pointer = NUM_HARTS-1 (hart 0 wins first).
//  - Capture: mvu_start[h] & !pending[h] -> slot h latches all csr fields, pending[h]<=1.
//    mvu_start[h] & pending[h] -> ignored, mvu_start_drop[h] pulses 1 cycle.
//    A start for the hart currently active is accepted (its slot was freed in LOAD).
//  - FSM IDLE: any pending -> grant first pending hart after rr pointer (wrapping); -> LOAD.
//  - LOAD (1 cycle): copy slot to working regs, clear pending[grant], rr<=grant, counters i=o=0,
//    pointers = bases; -> RUN. Start on same cycle as LOAD for the granted hart: start wins,
//    pending stays 1 with new descriptor; working regs get old descriptor.
//  - Latency: agu_valid high 2 clocks after the edge sampling mvu_start (edge k capture, k+1 LOAD, k+2 RUN).
//  - RUN: agu_valid=1; outputs held stable while !agu_ready. On valid&ready:
//    i<L0-1: i++, ptr += stride_0; else i=0, o++, outer_ptr += stride_1, ptr = new outer_ptr.
//    addr = base + o*stride_1 + i*stride_0, computed incrementally, mod 2^32.
//    agu_last = (i==L0-1)&&(o==L1-1). Handshake with agu_last -> DONE.
//  - Length 0 treated as 1. Strides are two's complement; negative strides wrap mod 2^32.
//  - DONE (1 cycle): agu_valid=0, mvu_irq[hart] pulses 1 cycle; -> IDLE.
//  - Reset mid-job: next cycle valid=0, no irq, all queued jobs discarded.
// CONFIGURATION
//  MVU_IRQ_STICKY_EN defined: mvu_irq[h] set in DONE, held until the next accepted mvu_start[h]
//    or rst. Not defined: mvu_irq[h] is a 1-cycle pulse.
// TESTING
//  1. hart0: wbase=0x100, wstride0=4, wstride1=0x40, L0=3, L1=2, ready=1 -> waddr 0x100,0x104,0x108,
//     0x140,0x144,0x148; last on 6th; mvu_irq[0] one pulse the cycle after.
//  2. Same job, agu_ready randomly low -> identical sequence; outputs stable while stalled.
//  3. Starts on harts 2 and 5 same cycle -> hart2 job then hart5; repeat both -> hart2 then hart5 (rr wraps).
//  4. Second start on hart1 while pending -> mvu_start_drop[1] pulse; first descriptor's addresses emitted.
//  5. L0=0, L1=0, wstride0=0xFFFFFFFC -> single tuple at bases, agu_last=1, then irq.
//  6. rst during RUN -> valid 0 next cycle, no irq, busy 0; sticky build: irq[0] holds until next start[0].

Source files
------------

// File: rtl/mvu_job_ctrl.sv
// MVU-side CSR job receiver: per-hart descriptor slots, round-robin job pick, 2-level address loop.
// Optional: define MVU_IRQ_STICKY_EN to hold mvu_irq[h] until the next accepted mvu_start[h] or rst.
module mvu_job_ctrl #(
  parameter int NUM_HARTS = 8,
  parameter int LEN_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_HARTS-1:0]         mvu_start,
  input  logic [32*NUM_HARTS-1:0]      csr_mvu_wbaseaddr,
  input  logic [32*NUM_HARTS-1:0]      csr_mvu_ibaseaddr,
  input  logic [32*NUM_HARTS-1:0]      csr_mvu_obaseaddr,
  input  logic [32*NUM_HARTS-1:0]      csr_mvu_wstride_0,
  input  logic [32*NUM_HARTS-1:0]      csr_mvu_wstride_1,
  input  logic [32*NUM_HARTS-1:0]      csr_mvu_istride_0,
  input  logic [32*NUM_HARTS-1:0]      csr_mvu_istride_1,
  input  logic [32*NUM_HARTS-1:0]      csr_mvu_ostride_0,
  input  logic [32*NUM_HARTS-1:0]      csr_mvu_ostride_1,
  input  logic [32*NUM_HARTS-1:0]      csr_mvu_wlength_0,
  input  logic [32*NUM_HARTS-1:0]      csr_mvu_wlength_1,
  input  logic [32*NUM_HARTS-1:0]      csr_mvu_precision,
  input  logic [32*NUM_HARTS-1:0]      csr_mvu_quant,
  output logic [NUM_HARTS-1:0]         mvu_irq,
  output logic [NUM_HARTS-1:0]         mvu_start_drop,
  output logic                         agu_valid,
  input  logic                         agu_ready,
  output logic [31:0]                  agu_waddr,
  output logic [31:0]                  agu_iaddr,
  output logic [31:0]                  agu_oaddr,
  output logic                         agu_last,
  output logic [$clog2(NUM_HARTS)-1:0] agu_hart,
  output logic [31:0]                  job_precision,
  output logic [31:0]                  job_quant,
  output logic                         busy,
  output logic [1:0]                   dbg_state
);
  localparam int HW = $clog2(NUM_HARTS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

  typedef struct packed {
    logic [31:0]      wbase, ibase, obase;
    logic [31:0]      ws0, ws1, is0, is1, os0, os1;
    logic [LEN_W-1:0] len0, len1;
    logic [31:0]      prec, quant;
  } desc_t;

  state_e               state, state_n;
  desc_t                in_desc [NUM_HARTS];
  desc_t                slot    [NUM_HARTS];
  desc_t                cur;
  logic [NUM_HARTS-1:0] pending, accept, clear, drop_n, drop_q, done_vec;
  logic [HW-1:0]        rr, grant_n, grant_q, hart_q;
  logic [LEN_W-1:0]     cnt_i, cnt_o, lim_i, lim_o;
  logic [31:0]          w_ptr, i_ptr, o_ptr, w_optr, i_optr, o_optr;
  logic                 any_pending, hs, at_last;
  logic                 unused_len_bits;

  assign unused_len_bits = ^{csr_mvu_wlength_0, csr_mvu_wlength_1};

  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      in_desc[h].wbase = csr_mvu_wbaseaddr[32*h +: 32];
      in_desc[h].ibase = csr_mvu_ibaseaddr[32*h +: 32];
      in_desc[h].obase = csr_mvu_obaseaddr[32*h +: 32];
      in_desc[h].ws0   = csr_mvu_wstride_0[32*h +: 32];
      in_desc[h].ws1   = csr_mvu_wstride_1[32*h +: 32];
      in_desc[h].is0   = csr_mvu_istride_0[32*h +: 32];
      in_desc[h].is1   = csr_mvu_istride_1[32*h +: 32];
      in_desc[h].os0   = csr_mvu_ostride_0[32*h +: 32];
      in_desc[h].os1   = csr_mvu_ostride_1[32*h +: 32];
      in_desc[h].len0  = csr_mvu_wlength_0[32*h +: LEN_W];
      in_desc[h].len1  = csr_mvu_wlength_1[32*h +: LEN_W];
      in_desc[h].prec  = csr_mvu_precision[32*h +: 32];
      in_desc[h].quant = csr_mvu_quant[32*h +: 32];
    end
  end

  // Walk from farthest to nearest so the first pending hart after rr wins.
  always_comb begin
    any_pending = |pending;
    grant_n     = rr;
    for (int k = NUM_HARTS; k >= 1; k--) begin
      if (pending[(int'(rr) + k) % NUM_HARTS]) grant_n = HW'((int'(rr) + k) % NUM_HARTS);
    end
  end

  // The granted slot is freed during LOAD, so a start arriving then is accepted, not dropped.
  always_comb begin
    clear = '0;
    if (state == S_LOAD) clear[grant_q] = 1'b1;
    accept = mvu_start & (~pending | clear);
    drop_n = mvu_start & pending & ~clear;
  end

  // Stream handshake: a tuple moves on a clock edge where agu_valid && agu_ready; while
  // agu_valid && !agu_ready every agu_* output holds its value.
  assign lim_i   = (cur.len0 == '0) ? '0 : cur.len0 - 1'b1;
  assign lim_o   = (cur.len1 == '0) ? '0 : cur.len1 - 1'b1;
  assign at_last = (cnt_i == lim_i) && (cnt_o == lim_o);
  assign hs      = (state == S_RUN) && agu_ready;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (any_pending) state_n = S_LOAD;
      S_LOAD:  state_n = S_RUN;
      S_RUN:   if (hs && at_last) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (accept[h]) slot[h] <= in_desc[h];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      drop_q  <= '0;
      rr      <= HW'(NUM_HARTS - 1);
      grant_q <= '0;
      hart_q  <= '0;
      cur     <= '0;
      cnt_i   <= '0;
      cnt_o   <= '0;
      w_ptr   <= '0;
      i_ptr   <= '0;
      o_ptr   <= '0;
      w_optr  <= '0;
      i_optr  <= '0;
      o_optr  <= '0;
    end else begin
      pending <= (pending & ~clear) | accept;
      drop_q  <= drop_n;
      if (state == S_IDLE) grant_q <= grant_n;
      if (state == S_LOAD) begin
        cur    <= slot[grant_q];
        rr     <= grant_q;
        hart_q <= grant_q;
        cnt_i  <= '0;
        cnt_o  <= '0;
        w_ptr  <= slot[grant_q].wbase;
        i_ptr  <= slot[grant_q].ibase;
        o_ptr  <= slot[grant_q].obase;
        w_optr <= slot[grant_q].wbase;
        i_optr <= slot[grant_q].ibase;
        o_optr <= slot[grant_q].obase;
      end else if (hs && !at_last) begin
        if (cnt_i != lim_i) begin
          cnt_i <= cnt_i + 1'b1;
          w_ptr <= w_ptr + cur.ws0;
          i_ptr <= i_ptr + cur.is0;
          o_ptr <= o_ptr + cur.os0;
        end else begin
          cnt_i  <= '0;
          cnt_o  <= cnt_o + 1'b1;
          w_optr <= w_optr + cur.ws1;
          i_optr <= i_optr + cur.is1;
          o_optr <= o_optr + cur.os1;
          w_ptr  <= w_optr + cur.ws1;
          i_ptr  <= i_optr + cur.is1;
          o_ptr  <= o_optr + cur.os1;
        end
      end
    end
  end

  always_comb begin
    done_vec = '0;
    if (state == S_DONE) done_vec[hart_q] = 1'b1;
  end

`ifdef MVU_IRQ_STICKY_EN
  logic [NUM_HARTS-1:0] irq_q;
  always_ff @(posedge clk) begin
    if (rst) irq_q <= '0;
    else     irq_q <= (irq_q & ~accept) | done_vec;
  end
  assign mvu_irq = irq_q | done_vec;
`else
  assign mvu_irq = done_vec;
`endif

  assign mvu_start_drop = drop_q;
  assign agu_valid      = (state == S_RUN);
  assign agu_last       = (state == S_RUN) && at_last;
  assign agu_waddr      = w_ptr;
  assign agu_iaddr      = i_ptr;
  assign agu_oaddr      = o_ptr;
  assign agu_hart       = hart_q;
  assign job_precision  = cur.prec;
  assign job_quant      = cur.quant;
  assign busy           = (state != S_IDLE) || any_pending;
  assign dbg_state      = state;
endmodule

// File: tb/tb_mvu_job_ctrl.sv
// Bench for mvu_job_ctrl: table-driven jobs, hand-written corner sequences and random jobs
// checked against a nested-loop address model with a tuple queue.
module tb_mvu_job_ctrl;
  localparam int NH    = 8;
  localparam int HW    = 3;
  localparam int LEN_W = 16;

  typedef struct {
    logic [31:0] wb, ws0, ws1, ib, is0, is1, ob, os0, os1, l0, l1, prec, quant;
  } desc_t;

  typedef struct packed {
    logic [HW-1:0] hart;
    logic [31:0]   w, i, o;
    logic          last;
    logic [31:0]   prec, quant;
  } item_t;

  localparam int W = $bits(item_t);

  typedef struct {
    int          hart;
    desc_t       d;
    int          exp_count;
    logic [31:0] exp_w, exp_i, exp_o;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NH-1:0] mvu_start = '0;
  logic [32*NH-1:0] csr_mvu_wbaseaddr = '0, csr_mvu_ibaseaddr = '0, csr_mvu_obaseaddr = '0;
  logic [32*NH-1:0] csr_mvu_wstride_0 = '0, csr_mvu_wstride_1 = '0;
  logic [32*NH-1:0] csr_mvu_istride_0 = '0, csr_mvu_istride_1 = '0;
  logic [32*NH-1:0] csr_mvu_ostride_0 = '0, csr_mvu_ostride_1 = '0;
  logic [32*NH-1:0] csr_mvu_wlength_0 = '0, csr_mvu_wlength_1 = '0;
  logic [32*NH-1:0] csr_mvu_precision = '0, csr_mvu_quant = '0;
  logic [NH-1:0] mvu_irq, mvu_start_drop;
  logic agu_valid, agu_last, busy;
  logic agu_ready = 1'b0;
  logic [31:0] agu_waddr, agu_iaddr, agu_oaddr, job_precision, job_quant;
  logic [HW-1:0] agu_hart;
  logic [1:0] dbg_state;

  mvu_job_ctrl #(.NUM_HARTS(NH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .mvu_start(mvu_start),
    .csr_mvu_wbaseaddr(csr_mvu_wbaseaddr), .csr_mvu_ibaseaddr(csr_mvu_ibaseaddr),
    .csr_mvu_obaseaddr(csr_mvu_obaseaddr),
    .csr_mvu_wstride_0(csr_mvu_wstride_0), .csr_mvu_wstride_1(csr_mvu_wstride_1),
    .csr_mvu_istride_0(csr_mvu_istride_0), .csr_mvu_istride_1(csr_mvu_istride_1),
    .csr_mvu_ostride_0(csr_mvu_ostride_0), .csr_mvu_ostride_1(csr_mvu_ostride_1),
    .csr_mvu_wlength_0(csr_mvu_wlength_0), .csr_mvu_wlength_1(csr_mvu_wlength_1),
    .csr_mvu_precision(csr_mvu_precision), .csr_mvu_quant(csr_mvu_quant),
    .mvu_irq(mvu_irq), .mvu_start_drop(mvu_start_drop),
    .agu_valid(agu_valid), .agu_ready(agu_ready),
    .agu_waddr(agu_waddr), .agu_iaddr(agu_iaddr), .agu_oaddr(agu_oaddr),
    .agu_last(agu_last), .agu_hart(agu_hart),
    .job_precision(job_precision), .job_quant(job_quant),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / ready generation ----------------
  always #5 clk = ~clk;

  int ready_mode = 1;  // 0 low, 1 high, 2 random
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       agu_ready = 1'b0;
      1:       agu_ready = 1'b1;
      default: agu_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  desc_t cur_desc [NH];
  vec_t  vecs [5];
  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;
  int model_rr = NH - 1;
  item_t last_item;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic desc_t mkd(input logic [31:0] wb, ws0, ws1, ib, is0, is1,
                                ob, os0, os1, l0, l1, prec, quant);
    desc_t d;
    d.wb = wb; d.ws0 = ws0; d.ws1 = ws1;
    d.ib = ib; d.is0 = is0; d.is1 = is1;
    d.ob = ob; d.os0 = os0; d.os1 = os1;
    d.l0 = l0; d.l1 = l1; d.prec = prec; d.quant = quant;
    return d;
  endfunction

  function automatic desc_t rand_desc();
    return mkd($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom,
               ($urandom & 32'hFFFF0000) | 32'($urandom_range(0, 4)),
               ($urandom & 32'hFFFF0000) | 32'($urandom_range(0, 3)),
               $urandom, $urandom);
  endfunction

  task automatic set_vec(input int idx, input int h, input desc_t d, input int cnt,
                         input logic [31:0] w, input logic [31:0] i, input logic [31:0] o);
    vecs[idx].hart = h; vecs[idx].d = d; vecs[idx].exp_count = cnt;
    vecs[idx].exp_w = w; vecs[idx].exp_i = i; vecs[idx].exp_o = o;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_desc(input int h, input desc_t d);
    cur_desc[h] = d;
    csr_mvu_wbaseaddr[32*h +: 32] = d.wb;
    csr_mvu_ibaseaddr[32*h +: 32] = d.ib;
    csr_mvu_obaseaddr[32*h +: 32] = d.ob;
    csr_mvu_wstride_0[32*h +: 32] = d.ws0;
    csr_mvu_wstride_1[32*h +: 32] = d.ws1;
    csr_mvu_istride_0[32*h +: 32] = d.is0;
    csr_mvu_istride_1[32*h +: 32] = d.is1;
    csr_mvu_ostride_0[32*h +: 32] = d.os0;
    csr_mvu_ostride_1[32*h +: 32] = d.os1;
    csr_mvu_wlength_0[32*h +: 32] = d.l0;
    csr_mvu_wlength_1[32*h +: 32] = d.l1;
    csr_mvu_precision[32*h +: 32] = d.prec;
    csr_mvu_quant[32*h +: 32]     = d.quant;
  endtask

  // Reference: address = base + o*stride_1 + i*stride_0 over the full loop nest.
  task automatic push_job(input int h);
    desc_t d;
    item_t it;
    int l0, l1;
    d  = cur_desc[h];
    l0 = int'(d.l0[LEN_W-1:0]);
    l1 = int'(d.l1[LEN_W-1:0]);
    if (l0 == 0) l0 = 1;
    if (l1 == 0) l1 = 1;
    for (int o = 0; o < l1; o++) begin
      for (int i = 0; i < l0; i++) begin
        it.hart  = HW'(h);
        it.w     = d.wb + 32'(o) * d.ws1 + 32'(i) * d.ws0;
        it.i     = d.ib + 32'(o) * d.is1 + 32'(i) * d.is0;
        it.o     = d.ob + 32'(o) * d.os1 + 32'(i) * d.os0;
        it.last  = (i == l0 - 1) && (o == l1 - 1);
        it.prec  = d.prec;
        it.quant = d.quant;
        exp_q.push_back(it);
      end
    end
  endtask

  task automatic pulse_start(input logic [NH-1:0] mask);
    @(posedge clk); #1 mvu_start = mask;
    @(posedge clk); #1 mvu_start = '0;
  endtask

  // Jobs started together run in round-robin order after the last granted hart.
  task automatic start_and_expect(input logic [NH-1:0] mask);
    int base;
    pulse_start(mask);
    base = model_rr;
    for (int k = 1; k <= NH; k++) begin
      int h;
      h = (base + k) % NH;
      if (mask[h]) begin
        push_job(h);
        model_rr = h;
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_done_in_budget", n < budget, 1'b1);
  endtask

  // ---------------- monitor ----------------
  logic prev_stall = 1'b0;
  logic done_prev  = 1'b0;
  logic [HW-1:0] done_hart = '0;
  item_t prev_item;

  always @(negedge clk) begin
    item_t cur_it;
    item_t exp_it;
    logic [NH-1:0] oh;
    cur_it.hart = agu_hart;  cur_it.w = agu_waddr; cur_it.i = agu_iaddr;
    cur_it.o = agu_oaddr;    cur_it.last = agu_last;
    cur_it.prec = job_precision; cur_it.quant = job_quant;
    if (rst) begin
      prev_stall = 1'b0;
      done_prev  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", agu_valid, 1'b1);
        check("stall_outputs_held", cur_it, prev_item);
      end
      oh = '0;
      oh[done_hart] = 1'b1;
`ifdef MVU_IRQ_STICKY_EN
      if (done_prev) check("irq_set", mvu_irq[done_hart], 1'b1);
`else
      if (done_prev) check("irq_pulse", mvu_irq, oh);
      else           check("irq_quiet", mvu_irq, '0);
`endif
      done_prev = 1'b0;
      if (agu_valid && agu_ready) begin
        hs_count++;
        last_item = cur_it;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tuple: got %0h expected no tuple", cur_it);
        end else begin
          exp_it = exp_q.pop_front();
          check("tuple", cur_it, exp_it);
        end
        done_prev = agu_last;
        done_hart = agu_hart;
      end
      prev_stall = agu_valid && !agu_ready;
      prev_item  = cur_it;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int base;
    logic [NH-1:0] mask;

    set_vec(0, 0, mkd(32'h100, 4, 32'h40, 32'h2000, 1, 32'h10, 32'h3000, 0, 8,
                      3, 2, 32'h11, 32'h22), 6, 32'h148, 32'h2012, 32'h3008);
    set_vec(1, 3, mkd(32'h0, 32'hFFFFFFFC, 32'h100, 32'h50, 0, 32'hFFFFFFFF, 32'h0, 1, 2,
                      0, 0, 32'h33, 32'h44), 1, 32'h0, 32'h50, 32'h0);
    set_vec(2, 7, mkd(32'h10, 32'hFFFFFFF0, 0, 32'h0, 2, 32'h20, 32'hFFFFFFFF, 1, 0,
                      2, 1, 32'h55, 32'h66), 2, 32'h0, 32'h2, 32'h0);
    set_vec(3, 5, mkd(32'hFFFFFFF8, 8, 0, 32'h1000, 4, 32'h100, 32'h40, 32'hFFFFFFFF, 32'h10,
                      2, 3, 32'h77, 32'h88), 6, 32'h0, 32'h1204, 32'h5F);
    set_vec(4, 1, mkd(32'h400, 32'h1000, 32'hFFFFFF00, 0, 0, 0, 32'h8, 3, 3,
                      1, 32'hABCD0004, 32'h99, 32'hAA), 4, 32'h100, 32'h0, 32'h11);

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", agu_valid, 1'b0);
    check("rst_last", agu_last, 1'b0);
    check("rst_irq", mvu_irq, '0);
    check("rst_drop", mvu_start_drop, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_addr", {agu_waddr, agu_iaddr, agu_oaddr}, '0);
    check("rst_job", {agu_hart, job_precision, job_quant}, '0);
    check("rst_state", dbg_state, 2'd0);

    // first job: two-clock start latency
    drive_desc(0, vecs[0].d);
    start_and_expect(8'h01);
    @(negedge clk);
    check("lat_capture_valid", agu_valid, 1'b0);
    check("lat_capture_busy", busy, 1'b1);
    @(negedge clk);
    check("lat_load_valid", agu_valid, 1'b0);
    @(negedge clk);
    check("lat_run_valid", agu_valid, 1'b1);
    check("lat_first_waddr", agu_waddr, 32'h100);
    wait_done(200);

`ifdef MVU_IRQ_STICKY_EN
    repeat (2) @(negedge clk);
    check("sticky_irq_held", mvu_irq[0], 1'b1);
    start_and_expect(8'h01);
    @(negedge clk);
    check("sticky_irq_cleared", mvu_irq[0], 1'b0);
    wait_done(200);
`endif

    // table of single jobs with hand-computed counts and final addresses
    for (int v = 0; v < 5; v++) begin
      base = hs_count;
      drive_desc(vecs[v].hart, vecs[v].d);
      start_and_expect(NH'(1) << vecs[v].hart);
      wait_done(200);
      check("vec_count", hs_count - base, vecs[v].exp_count);
      check("vec_last_w", last_item.w, vecs[v].exp_w);
      check("vec_last_i", last_item.i, vecs[v].exp_i);
      check("vec_last_o", last_item.o, vecs[v].exp_o);
      check("vec_last_flag", last_item.last, 1'b1);
    end

    // backpressure on the reference job
    ready_mode = 2;
    drive_desc(0, vecs[0].d);
    start_and_expect(8'h01);
    wait_done(400);
    ready_mode = 1;

    // start on a pending hart is dropped; the first descriptor runs
    ready_mode = 0;
    drive_desc(0, vecs[3].d);
    start_and_expect(8'h01);
    repeat (4) @(negedge clk);
    drive_desc(1, vecs[4].d);
    pulse_start(8'h02);
    push_job(1);
    model_rr = 1;
    drive_desc(1, vecs[2].d);
    pulse_start(8'h02);
    @(negedge clk);
    check("drop_pulse", mvu_start_drop, 8'h02);
    check("drop_busy", busy, 1'b1);
    @(negedge clk);
    check("drop_one_cycle", mvu_start_drop, 8'h00);
    ready_mode = 1;
    wait_done(400);

    // simultaneous starts on harts 2 and 5, twice (pointer wraps)
    drive_desc(2, vecs[1].d);
    drive_desc(5, vecs[0].d);
    start_and_expect(8'h24);
    wait_done(400);
    start_and_expect(8'h24);
    wait_done(400);

    // reset in the middle of a job with another job queued
    drive_desc(0, vecs[0].d);
    start_and_expect(8'h01);
    drive_desc(4, vecs[3].d);
    pulse_start(8'h10);
    base = hs_count;
    for (int n = 0; n < 50 && hs_count < base + 2; n++) @(negedge clk);
    check("midjob_progress", hs_count >= base + 2, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    model_rr = NH - 1;
    @(negedge clk);
    check("midrst_valid", agu_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_irq", mvu_irq, '0);
    check("midrst_state", dbg_state, 2'd0);
    repeat (5) @(negedge clk);
    check("midrst_stays_idle", {agu_valid, busy}, 2'b00);

    // random jobs on random hart sets with random backpressure
    ready_mode = 2;
    for (int r = 0; r < 15; r++) begin
      mask = NH'($urandom_range(1, (1 << NH) - 1));
      for (int h = 0; h < NH; h++) begin
        if (mask[h]) drive_desc(h, rand_desc());
      end
      start_and_expect(mask);
      wait_done(3000);
    end
    ready_mode = 1;

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("final_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
